// File: rtl/npc_control.sv
// Next-PC control with one delay slot; define NPC_CONTROL_LINK_EN for JAL/JALR link writes.
// PC-select outputs are combinational; link and slot_violation are registered (+1 cycle); stall holds PC and FSM.
module npc_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction_address,
  input  logic [31:0] instruction,
  input  logic        instruction_valid,
  input  logic        stall,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        control_use_npc,
  output logic [31:0] data_jump_address,
  output logic        link_write,
  output logic [4:0]  link_reg,
  output logic [31:0] link_address,
  output logic        slot_violation
);

  localparam logic [1:0] ST_SEQ      = 2'd0;
  localparam logic [1:0] ST_SLOT     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  logic [1:0]  state_q, state_d;
  logic [31:0] target_q, target_d;
  logic        slot_violation_q, slot_violation_d;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        is_j, is_jal, is_beq, is_bne, is_jr, is_jalr;
  logic        is_transfer;
  logic        taken;
  logic        accept;
  logic [31:0] pc_plus4;
  logic [31:0] branch_offset;
  logic [31:0] jump_target;
  logic [31:0] target;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  assign is_j    = (opcode == OP_J);
  assign is_jal  = (opcode == OP_JAL);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_jr   = (opcode == OP_SPECIAL) && (funct == FN_JR);
  assign is_jalr = (opcode == OP_SPECIAL) && (funct == FN_JALR);

  assign is_transfer = is_j | is_jal | is_beq | is_bne | is_jr | is_jalr;
  assign taken = is_j | is_jal | is_jr | is_jalr
               | (is_beq && (rs_data == rt_data))
               | (is_bne && (rs_data != rt_data));

  assign pc_plus4      = instruction_address + 32'd4;
  assign branch_offset = {{14{instruction[15]}}, instruction[15:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};

  always_comb begin
    target = pc_plus4 + branch_offset;
    if (is_j || is_jal) begin
      target = jump_target;
    end else if (is_jr || is_jalr) begin
      target = rs_data;
    end
  end

  // Nothing is taken in while the redirect is being applied.
  assign accept = instruction_valid && !stall && (state_q != ST_REDIRECT);

  always_comb begin
    state_d          = state_q;
    target_d         = target_q;
    slot_violation_d = 1'b0;
    if (!stall) begin
      case (state_q)
        ST_SEQ: begin
          if (accept && taken) begin
            target_d = target;
            state_d  = ST_SLOT;
          end
        end
        ST_SLOT: begin
          if (accept) begin
            state_d          = ST_REDIRECT;
            slot_violation_d = is_transfer;
          end
        end
        ST_REDIRECT: state_d = ST_SEQ;
        default:     state_d = ST_SEQ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_SEQ;
      target_q         <= 32'h0;
      slot_violation_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      target_q         <= target_d;
      slot_violation_q <= slot_violation_d;
    end
  end

  // Reset suppresses any redirect still pending from before it.
  always_comb begin
    control_use_npc   = 1'b1;
    data_jump_address = target_q;
    if (reset) begin
      control_use_npc   = 1'b1;
      data_jump_address = 32'h0;
    end else if (stall) begin
      control_use_npc   = 1'b0;
      data_jump_address = instruction_address;
    end else if (state_q == ST_REDIRECT) begin
      control_use_npc   = 1'b0;
      data_jump_address = target_q;
    end
  end

  assign slot_violation = slot_violation_q;

`ifdef NPC_CONTROL_LINK_EN
  logic        link_write_q, link_write_d;
  logic [4:0]  link_reg_q, link_reg_d;
  logic [31:0] link_address_q, link_address_d;

  // Links only fire from SEQ; a JAL/JALR in a delay slot is ignored.
  always_comb begin
    link_write_d   = accept && (state_q == ST_SEQ) && (is_jal || is_jalr);
    link_reg_d     = 5'd0;
    link_address_d = 32'h0;
    if (link_write_d) begin
      link_reg_d     = is_jal ? 5'd31 : instruction[15:11];
      link_address_d = instruction_address + 32'd8;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      link_write_q   <= 1'b0;
      link_reg_q     <= 5'd0;
      link_address_q <= 32'h0;
    end else begin
      link_write_q   <= link_write_d;
      link_reg_q     <= link_reg_d;
      link_address_q <= link_address_d;
    end
  end

  assign link_write   = link_write_q;
  assign link_reg     = link_reg_q;
  assign link_address = link_address_q;
`else
  assign link_write   = 1'b0;
  assign link_reg     = 5'd0;
  assign link_address = 32'h0;
`endif

endmodule

// File: tb/tb_npc_control.sv
// Directed bench for npc_control; inputs change 1ns after posedge, outputs checked at negedge.
module tb_npc_control;

  logic        clock;
  logic        reset;
  logic [31:0] instruction_address;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic        stall;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        control_use_npc;
  logic [31:0] data_jump_address;
  logic        link_write;
  logic [4:0]  link_reg;
  logic [31:0] link_address;
  logic        slot_violation;

  int vectors;
  int miscompares;

  npc_control dut (
    .clock               (clock),
    .reset               (reset),
    .instruction_address (instruction_address),
    .instruction         (instruction),
    .instruction_valid   (instruction_valid),
    .stall               (stall),
    .rs_data             (rs_data),
    .rt_data             (rt_data),
    .control_use_npc     (control_use_npc),
    .data_jump_address   (data_jump_address),
    .link_write          (link_write),
    .link_reg            (link_reg),
    .link_address        (link_address),
    .slot_violation      (slot_violation)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input logic [31:0] a, input logic [31:0] ins, input logic v, input logic s);
    instruction_address = a;
    instruction         = ins;
    instruction_valid   = v;
    stall               = s;
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rs_data = 32'h0;
    rt_data = 32'h0;
    drive(32'h0, 32'h0, 1'b1, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (control_use_npc !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_use_npc: got %b expected 1", control_use_npc);
    end
    vectors++;
    if (link_write !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_link_write: got %b expected 0", link_write);
    end
    vectors++;
    if (slot_violation !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_slot_violation: got %b expected 0", slot_violation);
    end
    vectors++;
    if (data_jump_address !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_target: got %h expected 00000000", data_jump_address);
    end
    next_cycle();
  endtask

  task automatic test_jump;
    drive(32'h0, 32'h08000040, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (control_use_npc !== 1'b1) begin
      miscompares++;
      $display("FAIL j_accept_use_npc: got %b expected 1", control_use_npc);
    end
    next_cycle();
    drive(32'h4, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (control_use_npc !== 1'b1) begin
      miscompares++;
      $display("FAIL j_slot_use_npc: got %b expected 1", control_use_npc);
    end
    next_cycle();
    drive(32'h8, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (control_use_npc !== 1'b0 || data_jump_address !== 32'h100) begin
      miscompares++;
      $display("FAIL j_redirect: got use_npc=%b addr=%h expected use_npc=0 addr=00000100",
               control_use_npc, data_jump_address);
    end
    next_cycle();
    drive(32'h100, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (control_use_npc !== 1'b1) begin
      miscompares++;
      $display("FAIL j_after_redirect: got %b expected 1", control_use_npc);
    end
    next_cycle();
  endtask

  task automatic test_branch;
    rs_data = 32'd5;
    rt_data = 32'd5;
    drive(32'h200, 32'h1000FFFF, 1'b1, 1'b0);
    next_cycle();
    drive(32'h204, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (control_use_npc !== 1'b1) begin
      miscompares++;
      $display("FAIL beq_slot_use_npc: got %b expected 1", control_use_npc);
    end
    next_cycle();
    drive(32'h208, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (control_use_npc !== 1'b0 || data_jump_address !== 32'h200) begin
      miscompares++;
      $display("FAIL beq_redirect: got use_npc=%b addr=%h expected use_npc=0 addr=00000200",
               control_use_npc, data_jump_address);
    end
    next_cycle();
    drive(32'h200, 32'h1400FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vectors++;
      if (control_use_npc !== 1'b1) begin
        miscompares++;
        $display("FAIL bne_not_taken[%0d]: got %b expected 1", i, control_use_npc);
      end
      next_cycle();
      drive(32'h204 + 32'(4 * i), 32'h0, 1'b1, 1'b0);
    end
    rs_data = 32'd1;
    rt_data = 32'd2;
    drive(32'h400, 32'h1000FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (control_use_npc !== 1'b1) begin
        miscompares++;
        $display("FAIL beq_not_taken[%0d]: got %b expected 1", i, control_use_npc);
      end
      next_cycle();
      drive(32'h404 + 32'(4 * i), 32'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_stall;
    drive(32'h300, 32'h08000080, 1'b1, 1'b0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(32'h304, 32'h0, 1'b1, 1'b1);
      @(negedge clock);
      vectors++;
      if (control_use_npc !== 1'b0 || data_jump_address !== 32'h304) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got use_npc=%b addr=%h expected use_npc=0 addr=00000304",
                 i, control_use_npc, data_jump_address);
      end
      next_cycle();
    end
    drive(32'h304, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (control_use_npc !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_slot_accept: got %b expected 1", control_use_npc);
    end
    next_cycle();
    drive(32'h308, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (control_use_npc !== 1'b0 || data_jump_address !== 32'h200) begin
      miscompares++;
      $display("FAIL stall_redirect: got use_npc=%b addr=%h expected use_npc=0 addr=00000200",
               control_use_npc, data_jump_address);
    end
    next_cycle();
  endtask

  task automatic test_link;
    logic        exp_lw;
    logic [4:0]  exp_reg_jal, exp_reg_jalr;
    logic [31:0] exp_la_jal, exp_la_jalr;
`ifdef NPC_CONTROL_LINK_EN
    exp_lw = 1'b1; exp_reg_jal = 5'd31; exp_la_jal = 32'h308;
    exp_reg_jalr = 5'd5; exp_la_jalr = 32'h508;
`else
    exp_lw = 1'b0; exp_reg_jal = 5'd0; exp_la_jal = 32'h0;
    exp_reg_jalr = 5'd0; exp_la_jalr = 32'h0;
`endif
    drive(32'h300, 32'h0C000080, 1'b1, 1'b0);
    next_cycle();
    drive(32'h304, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (link_write !== exp_lw || link_reg !== exp_reg_jal || link_address !== exp_la_jal) begin
      miscompares++;
      $display("FAIL jal_link: got w=%b reg=%0d addr=%h expected w=%b reg=%0d addr=%h",
               link_write, link_reg, link_address, exp_lw, exp_reg_jal, exp_la_jal);
    end
    next_cycle();
    drive(32'h308, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (link_write !== 1'b0 || control_use_npc !== 1'b0 || data_jump_address !== 32'h200) begin
      miscompares++;
      $display("FAIL jal_redirect: got w=%b use_npc=%b addr=%h expected w=0 use_npc=0 addr=00000200",
               link_write, control_use_npc, data_jump_address);
    end
    next_cycle();
    rs_data = 32'h400;
    drive(32'h500, 32'h00002809, 1'b1, 1'b0);
    next_cycle();
    drive(32'h504, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (link_write !== exp_lw || link_reg !== exp_reg_jalr || link_address !== exp_la_jalr) begin
      miscompares++;
      $display("FAIL jalr_link: got w=%b reg=%0d addr=%h expected w=%b reg=%0d addr=%h",
               link_write, link_reg, link_address, exp_lw, exp_reg_jalr, exp_la_jalr);
    end
    next_cycle();
    drive(32'h508, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (control_use_npc !== 1'b0 || data_jump_address !== 32'h400) begin
      miscompares++;
      $display("FAIL jalr_redirect: got use_npc=%b addr=%h expected use_npc=0 addr=00000400",
               control_use_npc, data_jump_address);
    end
    next_cycle();
  endtask

  task automatic test_slot_violation;
    drive(32'h0, 32'h08000040, 1'b1, 1'b0);
    next_cycle();
    drive(32'h4, 32'h08000080, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (slot_violation !== 1'b0) begin
      miscompares++;
      $display("FAIL sv_before: got %b expected 0", slot_violation);
    end
    next_cycle();
    drive(32'h8, 32'h0, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (slot_violation !== 1'b1) begin
      miscompares++;
      $display("FAIL sv_pulse: got %b expected 1", slot_violation);
    end
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'(4 * i), 32'h0, 1'b1, 1'b0);
      @(negedge clock);
      vectors++;
      if (control_use_npc !== 1'b1 || slot_violation !== 1'b0) begin
        miscompares++;
        $display("FAIL sv_after_reset[%0d]: got use_npc=%b sv=%b expected use_npc=1 sv=0",
                 i, control_use_npc, slot_violation);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_in_slot;
    drive(32'h0, 32'h08000040, 1'b1, 1'b0);
    next_cycle();
    reset = 1'b1;
    drive(32'h4, 32'h0, 1'b1, 1'b0);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'(4 * i), 32'h0, 1'b1, 1'b0);
      @(negedge clock);
      vectors++;
      if (control_use_npc !== 1'b1) begin
        miscompares++;
        $display("FAIL slot_reset_abort[%0d]: got %b expected 1", i, control_use_npc);
      end
      next_cycle();
    end
  endtask

  task automatic test_invalid_hold;
    drive(32'h40, 32'h08000040, 1'b1, 1'b0);
    next_cycle();
    drive(32'h44, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      vectors++;
      if (control_use_npc !== 1'b1) begin
        miscompares++;
        $display("FAIL invalid_hold[%0d]: got %b expected 1", i, control_use_npc);
      end
      next_cycle();
    end
    drive(32'h44, 32'h0, 1'b1, 1'b0);
    next_cycle();
    drive(32'h48, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (control_use_npc !== 1'b0 || data_jump_address !== 32'h100) begin
      miscompares++;
      $display("FAIL invalid_then_redirect: got use_npc=%b addr=%h expected use_npc=0 addr=00000100",
               control_use_npc, data_jump_address);
    end
    next_cycle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_jump();
    test_branch();
    test_stall();
    test_link();
    test_invalid_hold();
    test_slot_violation();
    test_reset_in_slot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
